instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue.sv | 103 ++++++++++
 tb/tb_instruction_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_queue
// Description : Show-ahead circular instruction queue between fetch and
//               decode. Holds {pc, instr} pairs, supports flush, and uses an
//               asynchronous active-low reset that also clears storage.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   PC,
    input  logic [31:0]   instr,
    input  logic          load_iq_fetch,
    input  logic          flush_iq_fetch,
    output logic          iq_really_full,
    output logic          iq_valid,
    output logic [31:0]   iq_pc,
    output logic [31:0]   iq_instr,
    input  logic          iq_deq,
    output logic [CW-1:0] iq_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [31:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_valid;
    logic w_enq;
    logic w_deq;

    // Status flags derive from the registered count only, so full has no
    // combinational path from any input.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);

    // Flush overrides both sides; a full queue ignores loads, an empty one
    // ignores dequeues.
    assign w_enq = load_iq_fetch & ~w_full  & ~flush_iq_fetch;
    assign w_deq = iq_deq        &  w_valid & ~flush_iq_fetch;

    assign iq_really_full = w_full;
    assign iq_valid       = w_valid;
    assign iq_count       = r_count;
    assign iq_pc          = r_pc_mem[r_head];
    assign iq_instr       = r_instr_mem[r_head];

    // Entry storage: cleared only by reset, never by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_enq) begin
            r_pc_mem[r_tail]    <= PC;
            r_instr_mem[r_tail] <= instr;
        end
    end

    // Head/tail pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush_iq_fetch) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_AW'(1);
            end
        end
    end

    // Occupancy count; simultaneous enqueue and dequeue leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush_iq_fetch) begin
            r_count <= '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_queue
// Description : Self-checking bench for instruction_queue (DEPTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_queue;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        load_iq_fetch;
    logic        flush_iq_fetch;
    logic        iq_really_full;
    logic        iq_valid;
    logic [31:0] iq_pc;
    logic [31:0] iq_instr;
    logic        iq_deq;
    logic [3:0]  iq_count;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .instr          (instr),
        .load_iq_fetch  (load_iq_fetch),
        .flush_iq_fetch (flush_iq_fetch),
        .iq_really_full (iq_really_full),
        .iq_valid       (iq_valid),
        .iq_pc          (iq_pc),
        .iq_instr       (iq_instr),
        .iq_deq         (iq_deq),
        .iq_count       (iq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ld;
        logic        dq;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        e_valid;
        logic        e_full;
        logic [3:0]  e_count;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return {p[19:0], 12'h013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, sample 1 after the rising edge.
    task automatic step(input logic ld, input logic dq, input logic fl,
                        input logic [31:0] p, input logic [31:0] ins);
        @(negedge clk);
        load_iq_fetch  = ld;
        iq_deq         = dq;
        flush_iq_fetch = fl;
        PC             = p;
        instr          = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        load_iq_fetch = 1'b0; iq_deq = 1'b0; flush_iq_fetch = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        PC = '0; instr = '0;
        load_iq_fetch = 1'b0; flush_iq_fetch = 1'b0; iq_deq = 1'b0;

        // Reset state, before any clock edge
        #2;
        chk("rst_valid", 32'(iq_valid), 32'd0);
        chk("rst_full",  32'(iq_really_full), 32'd0);
        chk("rst_count", 32'(iq_count), 32'd0);
        chk("rst_pc",    iq_pc, 32'd0);
        chk("rst_instr", iq_instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //           ld   dq   fl   pc          instr       valid full cnt  exp_pc      exp_instr
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h60,     32'h13,     1'b1,1'b0,4'd1,32'h60,     32'h13};
        vecs[1]  = '{1'b1,1'b1,1'b0,32'h64,     32'h0A,     1'b1,1'b0,4'd1,32'h64,     32'h0A};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,      32'h0,      1'b1,1'b0,4'd1,32'h64,     32'h0A};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,      32'h0,      1'b0,1'b0,4'd0,32'h0,      32'h0};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h0,      32'h0,      1'b0,1'b0,4'd0,32'h0,      32'h0};
        vecs[5]  = '{1'b1,1'b1,1'b0,32'h70,     32'h1,      1'b1,1'b0,4'd1,32'h70,     32'h1};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h74,     32'h2,      1'b1,1'b0,4'd2,32'h70,     32'h1};
        vecs[7]  = '{1'b1,1'b0,1'b0,32'h78,     32'h3,      1'b1,1'b0,4'd3,32'h70,     32'h1};
        vecs[8]  = '{1'b1,1'b1,1'b0,32'h7C,     32'h4,      1'b1,1'b0,4'd3,32'h74,     32'h2};
        vecs[9]  = '{1'b1,1'b1,1'b1,32'h90,     32'h9,      1'b0,1'b0,4'd0,32'h60,     32'h13};
        vecs[10] = '{1'b0,1'b0,1'b1,32'h0,      32'h0,      1'b0,1'b0,4'd0,32'h60,     32'h13};
        vecs[11] = '{1'b1,1'b0,1'b0,32'h200,    32'h55,     1'b1,1'b0,4'd1,32'h200,    32'h55};

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].ld, vecs[v].dq, vecs[v].fl, vecs[v].pc, vecs[v].ins);
            chk($sformatf("v%0d_valid", v), 32'(iq_valid), 32'(vecs[v].e_valid));
            chk($sformatf("v%0d_full",  v), 32'(iq_really_full), 32'(vecs[v].e_full));
            chk($sformatf("v%0d_count", v), 32'(iq_count), 32'(vecs[v].e_count));
            chk($sformatf("v%0d_pc",    v), iq_pc, vecs[v].e_pc);
            chk($sformatf("v%0d_instr", v), iq_instr, vecs[v].e_ins);
        end

        // Fill, overflow attempt, full load+deq, drain in order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h60 + 32'(4*i), instr_of(32'h60 + 32'(4*i)));
            chk("fill_count", 32'(iq_count), 32'(i + 1));
            chk("fill_full", 32'(iq_really_full), (i == 7) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h80, instr_of(32'h80));
        chk("ovf_count", 32'(iq_count), 32'd8);
        chk("ovf_full",  32'(iq_really_full), 32'd1);
        chk("ovf_head",  iq_pc, 32'h60);
        step(1'b1, 1'b1, 1'b0, 32'h84, instr_of(32'h84));
        chk("fulldq_count", 32'(iq_count), 32'd7);
        chk("fulldq_full",  32'(iq_really_full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("drain_pc",    iq_pc, 32'h60 + 32'(4*i));
            chk("drain_instr", iq_instr, instr_of(32'h60 + 32'(4*i)));
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("drain_count", 32'(iq_count), 32'(7 - i));
        end
        chk("drain_empty", 32'(iq_valid), 32'd0);
        chk("ovf_not_written", iq_pc, 32'h60);

        // Wrap-around: pointers both at 0 here
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h300 + 32'(4*i), instr_of(32'h300 + 32'(4*i)));
            chk("wr_fill_count", 32'(iq_count), 32'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            chk("wr_pre_pc", iq_pc, 32'h300 + 32'(4*i));
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("wr_pre_count", 32'(iq_count), 32'(5 - i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4*i), instr_of(32'h100 + 32'(4*i)));
            chk("wrap_fill_count", 32'(iq_count), 32'(i + 1));
            chk("wrap_head", iq_pc, 32'h100);
        end
        for (int i = 0; i < 5; i++) begin
            chk("wrap_pc",    iq_pc, 32'h100 + 32'(4*i));
            chk("wrap_instr", iq_instr, instr_of(32'h100 + 32'(4*i)));
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("wrap_count", 32'(iq_count), 32'(4 - i));
        end

        // Flush held for several cycles while fetch keeps loading
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h400 + 32'(4*i), instr_of(32'h400 + 32'(4*i)));
        end
        chk("preflush_count", 32'(iq_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'h500, 32'h1);
            chk("hold_flush_count", 32'(iq_count), 32'd0);
            chk("hold_flush_valid", 32'(iq_valid), 32'd0);
        end

        // Asynchronous reset between clock edges with count = 4
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h600 + 32'(4*i), instr_of(32'h600 + 32'(4*i)));
        end
        chk("pre_arst_count", 32'(iq_count), 32'd4);
        @(negedge clk);
        load_iq_fetch = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(iq_valid), 32'd0);
        chk("arst_count", 32'(iq_count), 32'd0);
        chk("arst_pc",    iq_pc, 32'd0);
        chk("arst_instr", iq_instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        load_iq_fetch = 1'b1;
        PC = 32'h60;
        instr = 32'h13;
        @(posedge clk);
        #1;
        chk("post_arst_count", 32'(iq_count), 32'd1);
        chk("post_arst_pc",    iq_pc, 32'h60);
        chk("post_arst_valid", 32'(iq_valid), 32'd1);
        @(negedge clk);
        load_iq_fetch = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
